// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable, mux select and the ALU op class.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  state_e state_q, state_d;

  logic ir_write_s;
  logic mem_write_s;
  logic reg_write_s;
  logic pc_write_s;
  logic branch_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    alu_op      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    iord        = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    pc_write_s  = 1'b0;
    branch_s    = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          state_d = S_EXECUTE;
        end else if (opcode == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (opcode == OP_ADDI) begin
          state_d = S_ADDIEX;
        end else if (opcode == OP_J) begin
          state_d = S_JUMP;
        end else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Anything other than a load/store here means the IR was corrupted; recover.
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
        state_d     = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch_s  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write_s = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Architectural writes are suppressed for as long as reset is held, not just at the edge.
  assign ir_write  = ir_write_s & ~reset;
  assign mem_write = mem_write_s & ~reset;
  assign reg_write = reg_write_s & ~reset;
  assign pc_en     = (pc_write_s | (branch_s & zero)) & ~reset;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through the FSM
// and compares state and control outputs against hand-derived expectations.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       pc_en;
  logic       illegal_op;
  logic [3:0] state;

  int checks;
  int errors;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .iord       (iord),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

  // Entry/exit contract for every task: just after a negedge, DUT in FETCH.
  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || ir_write !== 1'b0 || pc_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: state=%0d ir_write=%b pc_en=%b, expected 0 0 0", state, ir_write, pc_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1 || alu_src_b !== 2'b01) begin
      errors++;
      $display("FAIL reset_release_fetch: state=%0d ir_write=%b pc_en=%b alu_src_b=%b, expected 0 1 1 01",
               state, ir_write, pc_en, alu_src_b);
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd6) begin
      errors++;
      $display("FAIL reset_reach_execute: state=%0d, expected 6", state);
    end
    reset = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(negedge clk); #1;
      end
      checks++;
      if (state !== 4'd0 || ir_write !== 1'b0 || pc_en !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_execute[%0d]: state=%0d ir_w=%b pc_en=%b reg_w=%b mem_w=%b, expected 0 0 0 0 0",
                 c, state, ir_write, pc_en, reg_write, mem_write);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_release2: state=%0d ir_write=%b pc_en=%b, expected 0 1 1", state, ir_write, pc_en);
    end
  endtask

  task automatic test_lw();
    int exp_st[6] = '{0, 1, 2, 3, 4, 0};
    opcode = 6'b100011; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      checks++;
      if (state !== exp_st[i][3:0] || reg_write !== (exp_st[i] == 4) || mem_to_reg !== (exp_st[i] == 4)
          || alu_op !== 2'b00 || iord !== (exp_st[i] == 3)) begin
        errors++;
        $display("FAIL lw[%0d]: state=%0d reg_w=%b m2r=%b alu_op=%b iord=%b, expected state %0d",
                 i, state, reg_write, mem_to_reg, alu_op, iord, exp_st[i]);
      end
      // Opcode is only sampled in DECODE/MEMADR, so corrupting it in MEMRD must not matter.
      if (exp_st[i] == 3) opcode = 6'b000000;
    end
  endtask

  task automatic test_rtype();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      checks++;
      if (state !== exp_st[i][3:0] || alu_op !== ((exp_st[i] == 6) ? 2'b10 : 2'b00)
          || reg_dst !== (exp_st[i] == 7) || reg_write !== (exp_st[i] == 7)) begin
        errors++;
        $display("FAIL rtype[%0d]: state=%0d alu_op=%b reg_dst=%b reg_w=%b, expected state %0d",
                 i, state, alu_op, reg_dst, reg_write, exp_st[i]);
      end
    end
  endtask

  task automatic test_beq(input logic z);
    int exp_st[4] = '{0, 1, 8, 0};
    opcode = 6'b000100; mem_ready = 1'b1; zero = z;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      checks++;
      if (state !== exp_st[i][3:0]) begin
        errors++;
        $display("FAIL beq_z%0b_state[%0d]: got %0d, expected %0d", z, i, state, exp_st[i]);
      end
      if (exp_st[i] == 8) begin
        checks++;
        if (pc_en !== z || pc_src !== 2'b01 || alu_op !== 2'b01 || alu_src_a !== 1'b1) begin
          errors++;
          $display("FAIL beq_z%0b_branch: pc_en=%b pc_src=%b alu_op=%b src_a=%b, expected %b 01 01 1",
                   z, pc_en, pc_src, alu_op, alu_src_a, z);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_stall();
    int exp_st[3] = '{0, 1, 2};
    opcode = 6'b101011; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      checks++;
      if (state !== exp_st[i][3:0]) begin
        errors++;
        $display("FAIL sw_state[%0d]: got %0d, expected %0d", i, state, exp_st[i]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ready = (c == 3);
      #1;
      checks++;
      if (state !== 4'd5 || mem_write !== 1'b1 || iord !== 1'b1) begin
        errors++;
        $display("FAIL sw_memwr[%0d]: state=%0d mem_write=%b iord=%b, expected 5 1 1", c, state, mem_write, iord);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL sw_done: state=%0d mem_write=%b, expected 0 0", state, mem_write);
    end
  endtask

  task automatic test_fetch_stall();
    opcode = 6'b101011;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      mem_ready = (c == 2);
      #1;
      checks++;
      if (state !== 4'd0 || ir_write !== (c == 2) || pc_en !== (c == 2)) begin
        errors++;
        $display("FAIL fetch_stall[%0d]: state=%0d ir_write=%b pc_en=%b, expected 0 %b %b",
                 c, state, ir_write, pc_en, c == 2, c == 2);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL fetch_stall_decode: state=%0d, expected 1", state);
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd5) begin
      errors++;
      $display("FAIL fetch_stall_memwr: state=%0d, expected 5", state);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL fetch_stall_done: state=%0d, expected 0", state);
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      checks++;
      if (state !== ((i == 1) ? 4'd1 : 4'd0) || illegal_op !== (i == 1) || alu_op === 2'b11
          || (i == 1 && (reg_write !== 1'b0 || mem_write !== 1'b0 || pc_en !== 1'b0 || ir_write !== 1'b0))) begin
        errors++;
        $display("FAIL illegal[%0d]: state=%0d illegal_op=%b alu_op=%b reg_w=%b mem_w=%b pc_en=%b",
                 i, state, illegal_op, alu_op, reg_write, mem_write, pc_en);
      end
    end
  endtask

  task automatic test_jump();
    int exp_st[4] = '{0, 1, 11, 0};
    opcode = 6'b000010; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      checks++;
      if (state !== exp_st[i][3:0] || (exp_st[i] == 11 && (pc_src !== 2'b10 || pc_en !== 1'b1))
          || (exp_st[i] == 1 && pc_en !== 1'b0)) begin
        errors++;
        $display("FAIL jump[%0d]: state=%0d pc_src=%b pc_en=%b, expected state %0d",
                 i, state, pc_src, pc_en, exp_st[i]);
      end
    end
  endtask

  task automatic test_addi();
    int exp_st[5] = '{0, 1, 9, 10, 0};
    opcode = 6'b001000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      checks++;
      if (state !== exp_st[i][3:0] || reg_write !== (exp_st[i] == 10) || reg_dst !== 1'b0
          || (exp_st[i] == 9 && (alu_src_b !== 2'b10 || alu_src_a !== 1'b1))) begin
        errors++;
        $display("FAIL addi[%0d]: state=%0d reg_w=%b reg_dst=%b src_b=%b, expected state %0d",
                 i, state, reg_write, reg_dst, alu_src_b, exp_st[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw_stall();
    test_fetch_stall();
    test_illegal();
    test_jump();
    test_addi();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit instruction opcode and steps through the fetch, decode, execute, memory and writeback phases.
- Drives every datapath enable and mux select.
- Produces the 2-bit alu_op code consumed by the ALU control decoder; it is the producer end of that interface.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-if-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-high reset
- opcode  input  6  instr[31:26] from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- alu_op  output  2  00 = add, 01 = subtract, 10 = decode funct; 11 never driven
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  output  1  instruction register load
- mem_write  output  1  memory write strobe
- reg_write  output  1  register file write
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  0 = ALUOut, 1 = memory data
- pc_en  output  1  PC load enable = pc_write OR (branch AND zero)
- illegal_op  output  1  unrecognised opcode seen in DECODE
- state  output  4  current state, for debug

Behaviour:
- Moore FSM with a 4-bit registered state.
- All outputs are combinational from state, plus mem_ready and zero where noted.
- Every output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Encodings 12-15 transition to FETCH on the next clock, with all outputs 0.
- Reset: state goes to FETCH immediately, asynchronously. While reset is high, ir_write, pc_en, mem_write and reg_write are forced to 0.
- Reset mid-instruction abandons the instruction; no partial writes occur after reset asserts.
- FETCH:
  - Outputs: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=mem_ready, pc_en=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: LW/SW -> MEMADR, RTYPE -> EXECUTE, BEQ -> BRANCH, ADDI -> ADDIEX, J -> JUMP.
  - Any other opcode: illegal_op=1 for this cycle only, next state FETCH, no writes.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: LW -> MEMRD, SW -> MEMWR. The opcode is held stable by the IR.
- MEMRD:
  - Outputs: iord=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB:
  - Outputs: reg_dst=0, mem_to_reg=1, reg_write=1.
  - Next state FETCH.
- MEMWR:
  - Outputs: iord=1, mem_write=1 held every cycle until mem_ready=1.
  - Next state FETCH.
- EXECUTE:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state ALUWB.
- ALUWB:
  - Outputs: reg_dst=1, mem_to_reg=0, reg_write=1.
  - Next state FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; internal branch=1, so pc_en=zero.
  - Next state FETCH.
- ADDIEX:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state ADDIWB.
- ADDIWB:
  - Outputs: reg_dst=0, mem_to_reg=0, reg_write=1.
  - Next state FETCH.
- JUMP:
  - Outputs: pc_src=10, pc_en=1.
  - Next state FETCH.
- Instruction latency with mem_ready tied high: LW 5 cycles; SW, RTYPE and ADDI 4; BEQ and J 3. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- opcode is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- alu_op is never 11 in any state, including illegal encodings.

Test Plan:
- Reset high mid-EXECUTE -> state=0 in the same cycle; ir_write=pc_en=reg_write=mem_write=0 until reset drops; after release with mem_ready=1, FETCH asserts ir_write=1 and pc_en=1.
- mem_ready=1, opcode=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; alu_op=00 throughout.
- opcode=000000 -> states 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 and reg_write=1 in state 7.
- opcode=000100 -> states 0,1,8,0; with zero=1, pc_en=1 and pc_src=01 in state 8; repeat with zero=0 -> pc_en=0; alu_op=01 in state 8.
- opcode=101011 with mem_ready held 0 for 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles, then state 0; repeat with mem_ready=0 for 2 cycles in FETCH -> ir_write=0 for those cycles, DECODE delayed by 2 cycles.
- opcode=111111 -> illegal_op=1 for exactly one cycle in state 1, then state 0, no reg_write/mem_write; opcode=000010 -> states 0,1,11,0 with pc_src=10 and pc_en=1 in state 11.
